// File: rtl/i2c_slave_rx_timer.sv
// i2c_slave_rx_timer: I2C slave receive front end.
// Synchronises SCL/SDA, detects START/STOP, strobes data bits into the
// downstream shift register, flags completed bytes and times the ACK slot.
// Optional build macro I2C_RX_GLITCH_FILTER_EN inserts a 3-sample agreement
// filter after each synchroniser. This adds 2 clks of latency.
module i2c_slave_rx_timer #(
  parameter int SYNC_STAGES   = 2,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic scl_in,
  input  logic sda_in,
  input  logic ack_en,
  output logic shift_enable,
  output logic serial_in,
  output logic byte_received,
  output logic ack_phase,
  output logic sda_oe,
  output logic start_found,
  output logic stop_found,
  output logic bus_busy
);

  localparam int CW = $clog2(BITS_PER_BYTE + 1);
  localparam logic [CW-1:0] BPB = CW'(BITS_PER_BYTE);

  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_r, sda_r;
  logic scl_s, sda_s, scl_p, sda_p;
  logic rise, fall, start_ev, stop_ev;

  // Metastability synchronisers; idle bus is high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_r = scl_sync[SYNC_STAGES-1];
  assign sda_r = sda_sync[SYNC_STAGES-1];

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_fq, sda_fq;

  // Filter history. A line changes only once the current sample and the
  // two preceding samples agree. The held value doubles as the previous
  // sample for edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scl_h  <= '1;
      sda_h  <= '1;
      scl_fq <= 1'b1;
      sda_fq <= 1'b1;
    end else begin
      scl_h  <= {scl_h[0], scl_r};
      sda_h  <= {sda_h[0], sda_r};
      scl_fq <= scl_s;
      sda_fq <= sda_s;
    end
  end

  assign scl_s = (scl_r == scl_h[0] && scl_r == scl_h[1]) ? scl_r : scl_fq;
  assign sda_s = (sda_r == sda_h[0] && sda_r == sda_h[1]) ? sda_r : sda_fq;
  assign scl_p = scl_fq;
  assign sda_p = sda_fq;
`else
  logic scl_pq, sda_pq;

  // One-clk history of the synchronised lines for edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scl_pq <= 1'b1;
      sda_pq <= 1'b1;
    end else begin
      scl_pq <= scl_s;
      sda_pq <= sda_s;
    end
  end

  assign scl_s = scl_r;
  assign sda_s = sda_r;
  assign scl_p = scl_pq;
  assign sda_p = sda_pq;
`endif

  assign rise     =  scl_s & ~scl_p;
  assign fall     = ~scl_s &  scl_p;
  assign start_ev =  scl_s &  scl_p &  sda_p & ~sda_s;
  assign stop_ev  =  scl_s &  scl_p & ~sda_p &  sda_s;

  // Frame FSM with registered outputs. Priority is STOP > START > SCL edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      shift_enable  <= 1'b0;
      serial_in     <= 1'b1;
      byte_received <= 1'b0;
      ack_phase     <= 1'b0;
      sda_oe        <= 1'b0;
      start_found   <= 1'b0;
      stop_found    <= 1'b0;
      bus_busy      <= 1'b0;
    end else begin
      shift_enable  <= 1'b0;
      byte_received <= 1'b0;
      start_found   <= 1'b0;
      stop_found    <= 1'b0;
      if (stop_ev) begin
        state      <= IDLE;
        cnt        <= '0;
        sda_oe     <= 1'b0;
        ack_phase  <= 1'b0;
        bus_busy   <= 1'b0;
        stop_found <= 1'b1;
      end else if (start_ev) begin
        // START from idle and repeated START share the same entry.
        state       <= DATA;
        cnt         <= '0;
        sda_oe      <= 1'b0;
        ack_phase   <= 1'b0;
        bus_busy    <= 1'b1;
        start_found <= 1'b1;
      end else begin
        case (state)
          DATA: begin
            if (rise) begin
              shift_enable <= 1'b1;
              serial_in    <= sda_s;
              // Saturate; a well-formed frame falls before a further rise.
              if (cnt != BPB) cnt <= cnt + 1'b1;
            end else if (fall && cnt == BPB) begin
              byte_received <= 1'b1;
              ack_phase     <= 1'b1;
              sda_oe        <= ack_en;
              cnt           <= '0;
              state         <= ACK;
            end
          end
          ACK: begin
            // The ACK clock is not a data bit, so rises are ignored.
            if (fall) begin
              ack_phase <= 1'b0;
              sda_oe    <= 1'b0;
              state     <= DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
